xc_divrem_iter: RTL

//  Parametrised iterative divide/remainder unit for the MALU: computes quotient and remainder of XLEN-bit

---
 rtl/xc_divrem_iter_pkg.sv | 11 +
 rtl/xc_divrem_iter_if.sv | 22 ++
 rtl/xc_divrem_iter_step.sv | 17 +
 rtl/xc_divrem_iter.sv | 98 +++++++++
 4 files changed

// File: rtl/xc_divrem_iter_pkg.sv
// xc_divrem_iter_pkg: shared MALU multi-cycle unit state encodings and parameter legality check
package xc_divrem_iter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   function automatic bit steps_ok(input int xlen, input int steps);
      return (xlen >= 8) && (xlen % 2 == 0) && (steps == 1 || steps == 2 || steps == 4) && (xlen % steps == 0);
   endfunction
endpackage

// File: rtl/xc_divrem_iter_if.sv
// xc_divrem_iter_if: request/response handshake bundle of the divide unit
//  master drives req_* and rsp_ready; slave (the unit) drives req_ready and rsp_*
interface xc_divrem_iter_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic            req_signed;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_quotient;
   logic [XLEN-1:0] rsp_remainder;
   logic            rsp_div_zero;
   modport master (
      output req_valid, req_signed, req_rs1, req_rs2, rsp_ready,
      input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero
   );
   modport slave (
      input  req_valid, req_signed, req_rs1, req_rs2, rsp_ready,
      output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero
   );
endinterface

// File: rtl/xc_divrem_iter_step.sv
// xc_divrem_step: one combinational restoring-division step
//  i_rem  partial remainder (XLEN+1), i_bit next dividend bit, i_div divisor magnitude
//  o_rem  new partial remainder, o_q quotient bit
module xc_divrem_step #(parameter int XLEN = 32) (
   input  logic [XLEN:0]   i_rem,
   input  logic            i_bit,
   input  logic [XLEN-1:0] i_div,
   output logic [XLEN:0]   o_rem,
   output logic            o_q
);
   logic [XLEN+1:0] w_shift;
   logic [XLEN+1:0] w_diff;
   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {2'b0, i_div};
   assign o_q     = w_shift >= {2'b0, i_div};
   assign o_rem   = (XLEN+1)'(o_q ? w_diff : w_shift);
endmodule

// File: rtl/xc_divrem_iter.sv
// xc_divrem_iter: iterative signed/unsigned divide/remainder, STEPS quotient bits per cycle
//  clock, resetn (sync, active-low), i_flush abandons any operation
//  bus: slave side of xc_divrem_iter_if (request operands, response quotient/remainder/div-zero)
module xc_divrem_iter
   import xc_divrem_iter_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int STEPS = 1
) (
   input logic             clock,
   input logic             resetn,
   input logic             i_flush,
   xc_divrem_iter_if.slave bus
);
   localparam int K  = XLEN / STEPS;
   localparam int CW = $clog2(K) + 1;
   if (!steps_ok(XLEN, STEPS)) begin : g_bad_steps
      $error("xc_divrem_iter: illegal XLEN/STEPS combination");
   end
   state_t          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_dvd, r_div, r_quot, r_remout;
   logic [XLEN:0]   r_rem;
   logic            r_sign_q, r_sign_r, r_dz;
   logic            w_acc, w_zero, w_last;
   logic [XLEN-1:0] w_abs1, w_abs2, w_q, w_r;
   logic [XLEN-1:0] w_dvd [STEPS+1];
   logic [XLEN:0]   w_rem [STEPS+1];
   logic [STEPS-1:0] w_qb;
   assign bus.req_ready     = r_state == ST_IDLE;
   assign bus.rsp_valid     = r_state == ST_DONE;
   assign bus.rsp_quotient  = r_quot;
   assign bus.rsp_remainder = r_remout;
   assign bus.rsp_div_zero  = r_dz;
   assign w_acc  = bus.req_valid && bus.req_ready && !i_flush;
   assign w_zero = bus.req_rs2 == '0;
   assign w_last = r_state == ST_RUN && r_cnt == CW'(K - 1);
   assign w_abs1 = (bus.req_signed && bus.req_rs1[XLEN-1]) ? -bus.req_rs1 : bus.req_rs1;
   assign w_abs2 = (bus.req_signed && bus.req_rs2[XLEN-1]) ? -bus.req_rs2 : bus.req_rs2;
   // Quotient bits shift into the vacated low end of the dividend register,
   // so after K cycles r_dvd holds the unsigned quotient.
   assign w_dvd[0] = r_dvd;
   assign w_rem[0] = r_rem;
   for (genvar g = 0; g < STEPS; g++) begin : g_step
      xc_divrem_step #(.XLEN(XLEN)) u_step (
         .i_rem (w_rem[g]),
         .i_bit (w_dvd[g][XLEN-1]),
         .i_div (r_div),
         .o_rem (w_rem[g+1]),
         .o_q   (w_qb[g])
      );
      assign w_dvd[g+1] = {w_dvd[g][XLEN-2:0], w_qb[g]};
   end
   assign w_q = r_sign_q ? -w_dvd[STEPS] : w_dvd[STEPS];
   assign w_r = r_sign_r ? -XLEN'(w_rem[STEPS]) : XLEN'(w_rem[STEPS]);
   always_comb begin
      w_next = i_flush                ? ST_IDLE :
               r_state == ST_IDLE     ? (w_acc ? (w_zero ? ST_DONE : ST_RUN) : ST_IDLE) :
               r_state == ST_RUN      ? (w_last ? ST_DONE : ST_RUN) :
               bus.rsp_ready          ? ST_IDLE : ST_DONE;
   end
   always_ff @(posedge clock) begin
      r_state <= resetn ? w_next : ST_IDLE;
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_dvd    <= '0;
         r_div    <= '0;
         r_rem    <= '0;
         r_quot   <= '0;
         r_remout <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_dz     <= 1'b0;
      end else if (w_acc) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= w_abs1;
         r_div    <= w_abs2;
         r_sign_q <= bus.req_signed && (bus.req_rs1[XLEN-1] ^ bus.req_rs2[XLEN-1]);
         r_sign_r <= bus.req_signed && bus.req_rs1[XLEN-1];
         r_dz     <= w_zero;
         if (w_zero) begin
            r_quot   <= '1;
            r_remout <= bus.req_rs1;
         end
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt + CW'(1);
         r_dvd <= w_dvd[STEPS];
         r_rem <= w_rem[STEPS];
         if (w_last) begin
            r_quot   <= w_q;
            r_remout <= w_r;
         end
      end
   end
endmodule
